// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: writeback-source encodings, load/store
// size codes and the memory-stage FSM states.
package riscv_pkg;

    localparam logic [1:0] MR_ALU = 2'b00;
    localparam logic [1:0] MR_MEM = 2'b01;
    localparam logic [1:0] MR_PC4 = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational data-memory lane handling: store byte enables and replicated
// write data, load byte/half extraction with extension, and access legality.
module mem_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        access_err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        bad_f3;
    logic        misaligned;

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

    // Stores have no unsigned variants, so 100/101 are only legal for loads.
    always_comb begin
        if (is_store)
            bad_f3 = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        else
            bad_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        access_err = bad_f3 | misaligned;
    end

endmodule

// File: rtl/mem_stage.sv
// RV32 memory-access stage: drives a request/ready data-memory port for loads
// and stores, stalls upstream while a transaction is in flight, feeds MEM/WB.
module mem_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch,
    input  logic        memRW,
    input  logic        RegW,
    input  logic [1:0]  MemReg,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [31:0] pc_branch,
    input  logic [31:0] pc_add4,
    input  logic [31:0] alu_in,
    input  logic [31:0] data_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        pc_sel,
    output logic [31:0] pc_target,
    output logic        mem_err,
    output logic        RegW_out,
    output logic [1:0]  MemReg_out,
    output logic [4:0]  rd_out,
    output logic [31:0] alu_out,
    output logic [31:0] mem_data_out,
    output logic [31:0] pc_add4_out
);

    mem_state_t  state_reg, state_next;
    logic [31:0] load_data_reg, load_data_next;
    logic        req_next, we_next, err_next;
    logic [31:0] addr_next, wdata_next;
    logic [3:0]  be_next;
    logic        stall_fsm, wb_load;
    logic [31:0] wb_mem_data;

    logic        mem_op;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_load;
    logic        access_err;

    assign mem_op    = memRW | (MemReg == MR_MEM);
    assign pc_sel    = branch;
    assign pc_target = pc_branch;
    // Held low in reset so upstream is released even with a memory op presented.
    assign stall     = rst_n & stall_fsm;

    // Upstream is frozen by stall, so the live inputs still describe the access in REQ.
    mem_align u_align (
        .funct3     (funct3),
        .is_store   (memRW),
        .addr_lo    (alu_in[1:0]),
        .store_data (data_in),
        .rdata      (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load),
        .access_err (access_err)
    );

    always_comb begin
        state_next     = state_reg;
        stall_fsm      = 1'b0;
        wb_load        = 1'b0;
        wb_mem_data    = 32'h0;
        req_next       = dmem_req;
        we_next        = dmem_we;
        addr_next      = dmem_addr;
        be_next        = dmem_be;
        wdata_next     = dmem_wdata;
        err_next       = 1'b0;
        load_data_next = load_data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!mem_op) begin
                    wb_load = 1'b1;
                end else if (access_err) begin
                    err_next = 1'b1;
                end else begin
                    stall_fsm  = 1'b1;
                    req_next   = 1'b1;
                    we_next    = memRW;
                    addr_next  = {alu_in[31:2], 2'b00};
                    be_next    = lane_be;
                    wdata_next = memRW ? lane_wdata : 32'h0;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                stall_fsm = 1'b1;
                if (dmem_ready) begin
                    load_data_next = lane_load;
                    req_next       = 1'b0;
                    state_next     = ST_DONE;
                end
            end
            ST_DONE: begin
                wb_load     = 1'b1;
                wb_mem_data = memRW ? 32'h0 : load_data_reg;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            load_data_reg <= 32'h0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'h0;
            dmem_be       <= 4'b0000;
            dmem_wdata    <= 32'h0;
            mem_err       <= 1'b0;
            RegW_out      <= 1'b0;
            MemReg_out    <= MR_ALU;
            rd_out        <= 5'd0;
            alu_out       <= 32'h0;
            mem_data_out  <= 32'h0;
            pc_add4_out   <= 32'h0;
        end else begin
            state_reg     <= state_next;
            load_data_reg <= load_data_next;
            dmem_req      <= req_next;
            dmem_we       <= we_next;
            dmem_addr     <= addr_next;
            dmem_be       <= be_next;
            dmem_wdata    <= wdata_next;
            // Error pulse lines up with the bubble it leaves in MEM/WB.
            mem_err       <= err_next;
            if (wb_load) begin
                RegW_out     <= RegW;
                MemReg_out   <= MemReg;
                rd_out       <= rd;
                alu_out      <= alu_in;
                mem_data_out <= wb_mem_data;
                pc_add4_out  <= pc_add4;
            end else begin
                RegW_out     <= 1'b0;
                MemReg_out   <= MR_ALU;
                rd_out       <= 5'd0;
                alu_out      <= 32'h0;
                mem_data_out <= 32'h0;
                pc_add4_out  <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected MEM/WB entries are queued at issue
// and popped when the stage releases the instruction.
module tb_mem_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch, memRW, RegW;
    logic [1:0]  MemReg;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] pc_branch, pc_add4, alu_in, data_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall, pc_sel, mem_err;
    logic [31:0] pc_target;
    logic        RegW_out;
    logic [1:0]  MemReg_out;
    logic [4:0]  rd_out;
    logic [31:0] alu_out, mem_data_out, pc_add4_out;

    typedef struct packed {
        logic        regw;
        logic [1:0]  memreg;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mdata;
        logic [31:0] pc4;
    } wb_t;

    wb_t sb_q[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    int          stalls;
    logic        saw_req, q_we;
    logic [31:0] q_addr, q_wdata;
    logic [3:0]  q_be;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .branch(branch), .memRW(memRW), .RegW(RegW),
        .MemReg(MemReg), .funct3(funct3), .rd(rd), .pc_branch(pc_branch),
        .pc_add4(pc_add4), .alu_in(alu_in), .data_in(data_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .stall(stall), .pc_sel(pc_sel),
        .pc_target(pc_target), .mem_err(mem_err), .RegW_out(RegW_out),
        .MemReg_out(MemReg_out), .rd_out(rd_out), .alu_out(alu_out),
        .mem_data_out(mem_data_out), .pc_add4_out(pc_add4_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one instruction, answers the bus after wait_n REQ cycles, and
    // compares the MEM/WB entry against the scoreboard once the stage releases it.
    task automatic run_instr(input string name, input logic [2:0] f3, input logic st,
                             input logic [1:0] mr, input logic regw, input logic [4:0] rd_i,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic [31:0] rdat, input int wait_n,
                             input logic [31:0] exp_mdata, input logic exp_err,
                             input logic probe);
        wb_t e;
        wb_t pushed;
        int  reqc;
        bit  done;
        pushed = exp_err ? '0 : {regw, mr, rd_i, addr, exp_mdata, 32'h1000 + {27'h0, rd_i}};
        sb_q.push_back(pushed);
        funct3 = f3; memRW = st; MemReg = mr; RegW = regw; rd = rd_i;
        alu_in = addr; data_in = data; pc_add4 = 32'h1000 + {27'h0, rd_i};
        branch = 1'b0; pc_branch = 32'h0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
        stalls = 0; saw_req = 1'b0; reqc = 0; done = 1'b0;
        q_addr = 32'h0; q_be = 4'h0; q_wdata = 32'h0; q_we = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall) stalls++;
            if (dmem_req) begin
                if (!saw_req) begin
                    saw_req = 1'b1;
                    q_addr = dmem_addr; q_be = dmem_be; q_wdata = dmem_wdata; q_we = dmem_we;
                    if (probe) begin
                        branch = 1'b1; pc_branch = 32'h400;
                        #1;
                        check({name, " pc_sel"}, {31'h0, pc_sel}, 32'h1);
                        check({name, " pc_target"}, pc_target, 32'h400);
                        check({name, " bubble in REQ"}, {31'h0, RegW_out}, 32'h0);
                    end
                end
                if (reqc == wait_n) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = rdat;
                end
                reqc++;
            end
            if (!stall) done = 1'b1;
            @(posedge clk); #1;
            dmem_ready = 1'b0;
            dmem_rdata = 32'hDEAD_BEEF;
        end
        check({name, " completes"}, {31'h0, done}, 32'h1);
        e = sb_q.pop_front();
        check({name, " RegW_out"}, {31'h0, RegW_out}, {31'h0, e.regw});
        check({name, " MemReg_out"}, {30'h0, MemReg_out}, {30'h0, e.memreg});
        check({name, " rd_out"}, {27'h0, rd_out}, {27'h0, e.rd});
        check({name, " alu_out"}, alu_out, e.alu);
        check({name, " mem_data_out"}, mem_data_out, e.mdata);
        check({name, " pc_add4_out"}, pc_add4_out, e.pc4);
        check({name, " mem_err"}, {31'h0, mem_err}, {31'h0, exp_err});
        $display("txn %s: stalls=%0d req=%0b addr=%h be=%b we=%b wdata=%h mdata=%h err=%b",
                 name, stalls, saw_req, q_addr, q_be, q_we, q_wdata, mem_data_out, mem_err);
    endtask

    initial begin
        rst_n = 1'b0; branch = 1'b0; memRW = 1'b0; RegW = 1'b0; MemReg = MR_ALU;
        funct3 = 3'b000; rd = 5'd0; pc_branch = 32'h0; pc_add4 = 32'h0;
        alu_in = 32'h0; data_in = 32'h0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst dmem_req", {31'h0, dmem_req}, 32'h0);
        check("rst dmem_we", {31'h0, dmem_we}, 32'h0);
        check("rst dmem_addr", dmem_addr, 32'h0);
        check("rst dmem_be", {28'h0, dmem_be}, 32'h0);
        check("rst dmem_wdata", dmem_wdata, 32'h0);
        check("rst mem_err", {31'h0, mem_err}, 32'h0);
        check("rst stall", {31'h0, stall}, 32'h0);
        check("rst RegW_out", {31'h0, RegW_out}, 32'h0);
        check("rst rd_out", {27'h0, rd_out}, 32'h0);
        check("rst MemReg_out", {30'h0, MemReg_out}, 32'h0);
        check("rst alu_out", alu_out, 32'h0);
        check("rst mem_data_out", mem_data_out, 32'h0);
        check("rst pc_add4_out", pc_add4_out, 32'h0);
        rst_n = 1'b1;

        // ALU op: one cycle to MEM/WB, no stall
        run_instr("alu", 3'b000, 1'b0, MR_ALU, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 0,
                  32'h0, 1'b0, 1'b0);
        check("alu stalls", stalls, 0);
        check("alu no req", {31'h0, saw_req}, 32'h0);
        check("alu pc_sel", {31'h0, pc_sel}, 32'h0);

        // LB with two wait cycles, branch probed mid-transaction
        run_instr("lb", F3_B, 1'b0, MR_MEM, 1'b1, 5'd7, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 2,
                  32'hFFFF_FF80, 1'b0, 1'b1);
        check("lb addr", q_addr, 32'h100);
        check("lb be", {28'h0, q_be}, 32'h8);
        check("lb we", {31'h0, q_we}, 32'h0);
        check("lb stalls", stalls, 4);
        check("lb req dropped", {31'h0, dmem_req}, 32'h0);

        // SH, ready in first REQ cycle
        run_instr("sh", F3_H, 1'b1, MR_ALU, 1'b0, 5'd0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0,
                  32'h0, 1'b0, 1'b0);
        check("sh be", {28'h0, q_be}, 32'hC);
        check("sh wdata", q_wdata, 32'hABCD_ABCD);
        check("sh we", {31'h0, q_we}, 32'h1);
        check("sh stalls", stalls, 2);

        // Misaligned LW: error pulse, no bus access
        run_instr("lw_mis", F3_W, 1'b0, MR_MEM, 1'b1, 5'd9, 32'h0000_0101, 32'h0, 32'h0, 0,
                  32'h0, 1'b1, 1'b0);
        check("lw_mis no req", {31'h0, saw_req}, 32'h0);
        check("lw_mis stalls", stalls, 0);

        // JAL-style link writeback also shows the error pulse ended
        run_instr("jal", 3'b000, 1'b0, MR_PC4, 1'b1, 5'd1, 32'h0000_0888, 32'h0, 32'h0, 0,
                  32'h0, 1'b0, 1'b0);

        run_instr("lhu", F3_HU, 1'b0, MR_MEM, 1'b1, 5'd10, 32'h0000_0106, 32'h0, 32'h8765_4321, 1,
                  32'h0000_8765, 1'b0, 1'b0);
        check("lhu be", {28'h0, q_be}, 32'hC);
        check("lhu stalls", stalls, 3);

        run_instr("lbu", F3_BU, 1'b0, MR_MEM, 1'b1, 5'd11, 32'h0000_0041, 32'h0, 32'h0000_AB00, 0,
                  32'h0000_00AB, 1'b0, 1'b0);
        check("lbu addr", q_addr, 32'h40);

        run_instr("lh", F3_H, 1'b0, MR_MEM, 1'b1, 5'd12, 32'h0000_0050, 32'h0, 32'h1234_F00D, 0,
                  32'hFFFF_F00D, 1'b0, 1'b0);

        run_instr("sb", F3_B, 1'b1, MR_ALU, 1'b0, 5'd0, 32'h0000_0003, 32'h1234_565A, 32'h0, 1,
                  32'h0, 1'b0, 1'b0);
        check("sb be", {28'h0, q_be}, 32'h8);
        check("sb wdata", q_wdata, 32'h5A5A_5A5A);

        run_instr("sw", F3_W, 1'b1, MR_ALU, 1'b0, 5'd0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 0,
                  32'h0, 1'b0, 1'b0);
        check("sw be", {28'h0, q_be}, 32'hF);
        check("sw wdata", q_wdata, 32'hCAFE_F00D);
        check("sw addr", q_addr, 32'h10);

        run_instr("lw", F3_W, 1'b0, MR_MEM, 1'b1, 5'd13, 32'h0000_0020, 32'h0, 32'h0BAD_C0DE, 0,
                  32'h0BAD_C0DE, 1'b0, 1'b0);

        // Store with an unsigned size code is illegal
        run_instr("st_f3_100", 3'b100, 1'b1, MR_ALU, 1'b0, 5'd0, 32'h0000_0020, 32'h0, 32'h0, 0,
                  32'h0, 1'b1, 1'b0);
        check("st_f3_100 no req", {31'h0, saw_req}, 32'h0);

        // Reset asserted while REQ is outstanding
        funct3 = F3_W; memRW = 1'b0; MemReg = MR_MEM; RegW = 1'b1; rd = 5'd14;
        alu_in = 32'h0000_0300; branch = 1'b0; dmem_ready = 1'b0;
        @(posedge clk); #1;
        check("rstreq in REQ", {31'h0, dmem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rstreq dmem_req", {31'h0, dmem_req}, 32'h0);
        check("rstreq RegW_out", {31'h0, RegW_out}, 32'h0);
        check("rstreq rd_out", {27'h0, rd_out}, 32'h0);
        check("rstreq stall", {31'h0, stall}, 32'h0);
        $display("txn rst_mid_req: req=%b stall=%b RegW_out=%b", dmem_req, stall, RegW_out);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_instr("alu_after_rst", 3'b000, 1'b0, MR_ALU, 1'b1, 5'd20, 32'h0000_5555, 32'h0, 32'h0, 0,
                  32'h0, 1'b0, 1'b0);
        check("alu_after_rst stalls", stalls, 0);
        check("scoreboard drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
